shiftreg_rx_ctrl: RTL

Sequences a serial-in shift register to assemble N-bit words from a strobed serial bit stream. It frames each word with a start pulse and counts bits. It transfers each completed word into a holding register and presents it on a valid/ready handshake. It sits between a serial line front-end and any parallel word consumer, and flags words lost to consumer back-pressure.

---
 rtl/shiftreg_rx_ctrl_if.sv | 15 +
 rtl/shiftreg_rx_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/shiftreg_rx_ctrl_if.sv
// Word output handshake between the serial receiver and its parallel consumer.
//   dout       : received word (producer -> consumer)
//   dout_valid : dout holds an unconsumed word
//   dout_ready : consumer accepts dout when dout_valid & dout_ready
// master = receiver side, slave = consumer side.
interface shiftreg_rx_ctrl_if #(
  parameter int N = 8
);
  logic [N-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;

  modport master (output dout, output dout_valid, input  dout_ready);
  modport slave  (input  dout, input  dout_valid, output dout_ready);
endinterface

// File: rtl/shiftreg_rx_ctrl.sv
// Serial-in word assembler. Frames a word on start, shifts in N bits MSB
// first on bit_en strobes, and hands each completed word to a holding
// register exposed on a valid/ready handshake. Words arriving while the
// holding register is still full (and not being accepted) are dropped and
// flagged in the sticky overrun bit.
//   clk, reset   : clock, synchronous active-low reset
//   start        : frame start / restart (aborts a partial frame)
//   cont         : 1 = keep shifting after each word, 0 = return to idle
//   bit_en, sin  : bit strobe and serial data
//   rx           : dout / dout_valid / dout_ready handshake (master)
//   busy         : frame in progress
//   bit_cnt      : bits captured in current frame (0..N-1)
//   overrun, clr_ovr : sticky drop flag and its clear
module shiftreg_rx_ctrl #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          cont,
  input  logic          bit_en,
  input  logic          sin,
  shiftreg_rx_ctrl_if.master rx,
  output logic          busy,
  output logic [CW-1:0] bit_cnt,
  output logic          overrun,
  input  logic          clr_ovr
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  dout_q;
  logic          valid_q;
  logic          ovr_q;
  logic          word_done;
  logic [N-1:0]  new_word;
  logic          accept;
  logic          drop;

  assign new_word = {sreg_q[N-2:0], sin};
  assign accept   = valid_q & rx.dout_ready;
  // A completed word can only land if the register is empty or being
  // drained in this very cycle; otherwise it is lost.
  assign drop     = word_done & valid_q & ~rx.dout_ready;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    case (state_q)
      IDLE: begin
        // A bit strobed together with start is not part of the new frame.
        if (start) begin
          state_d = SHIFT;
          sreg_d  = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          sreg_d = '0;
          cnt_d  = '0;
        end else if (bit_en) begin
          if (cnt_q == CW'(N-1)) begin
            word_done = 1'b1;
            sreg_d    = '0;
            cnt_d     = '0;
            state_d   = cont ? SHIFT : IDLE;
          end else begin
            sreg_d = new_word;
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      if (word_done && !drop) begin
        dout_q  <= new_word;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
      // Set beats clear when both happen in one cycle.
      if (drop)         ovr_q <= 1'b1;
      else if (clr_ovr) ovr_q <= 1'b0;
    end
  end

  assign rx.dout       = dout_q;
  assign rx.dout_valid = valid_q;
  assign busy          = (state_q == SHIFT);
  assign bit_cnt       = cnt_q;
  assign overrun       = ovr_q;

endmodule
